// File: rtl/fp_pkg.sv
// fp_pkg: shared constants and types for the multiplier / N-root datapath.
//   MANT_W  - mantissa width (24, hidden bit at position 23)
//   EXP_W   - biased exponent width
//   SHAMT_W - normalisation shift-count width (0..24 fits in 5 bits)
//   fp_unpacked_t - {sign, exp, mant} carried between datapath stages
package fp_pkg;
    localparam int MANT_W  = 24;
    localparam int EXP_W   = 8;
    localparam int SHAMT_W = 5;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] mant;
    } fp_unpacked_t;
endpackage

// File: rtl/lzc24.sv
// lzc24: combinational 24-bit leading-zero counter.
//   mant  in  24  value to scan
//   count out 5   number of leading zeros, 24 when mant == 0
//   zero  out 1   mant is all zeros
module lzc24
    import fp_pkg::*;
(
    input  logic [MANT_W-1:0]  mant,
    output logic [SHAMT_W-1:0] count,
    output logic               zero
);
    // Scan LSB to MSB so the highest set bit is the last one to write count.
    always_comb begin
        count = SHAMT_W'(MANT_W);
        for (int i = 0; i < MANT_W; i++) begin
            if (mant[i]) count = SHAMT_W'(MANT_W - 1 - i);
        end
    end

    assign zero = ~|mant;
endmodule

// File: rtl/mult_norm_pipe.sv
// mult_norm_pipe: two-stage mantissa normalisation with valid/ready on both sides.
//   S1 counts leading zeros, picks the shift and adjusted exponent, sets flags.
//   S2 applies the left shift and holds the output beat.
// Ports:
//   clk, rst (async, active high)
//   in_valid/in_ready, in_sign, in_exp, in_mant     - upstream beat
//   out_valid/out_ready, out_sign, out_exp, out_mant,
//   out_zero, out_uflow                             - downstream beat
// Build option: MULT_NORM_DENORM_EN selects gradual underflow (defined) or
// flush-to-zero (undefined) when the exponent cannot absorb the full shift.
module mult_norm_pipe #(
    parameter int MANT_W = fp_pkg::MANT_W,
    parameter int EXP_W  = fp_pkg::EXP_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic [MANT_W-1:0] in_mant,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sign,
    output logic [EXP_W-1:0]  out_exp,
    output logic [MANT_W-1:0] out_mant,
    output logic              out_zero,
    output logic              out_uflow
);
    localparam int SHAMT_W = fp_pkg::SHAMT_W;

    fp_pkg::fp_unpacked_t s1_d, s1_q;
    logic [SHAMT_W-1:0]   shamt_d, s1_shamt, lz;
    logic                 zero_d, uflow_d, s1_zero, s1_uflow;
    logic                 all_zero;
    logic                 s1_valid, s2_valid, s2_load;

    lzc24 u_lzc (
        .mant  (in_mant),
        .count (lz),
        .zero  (all_zero)
    );

    // S2 can take a beat when empty or when its beat leaves this cycle;
    // S1 likewise when empty or draining into S2.
    assign s2_load  = !s2_valid || out_ready;
    assign in_ready = !s1_valid || s2_load;
    assign out_valid = s2_valid;

    // Case split keeps the exponent subtraction from ever wrapping.
    always_comb begin
        s1_d.sign = in_sign;
        s1_d.exp  = '0;
        s1_d.mant = in_mant;
        shamt_d   = '0;
        zero_d    = 1'b0;
        uflow_d   = 1'b0;
        if (all_zero) begin
            zero_d = 1'b1;
        end else if (in_exp == '0) begin
`ifndef MULT_NORM_DENORM_EN
            s1_d.mant = '0;
            zero_d    = 1'b1;
`endif
        end else if (in_exp > EXP_W'(lz)) begin
            shamt_d  = lz;
            s1_d.exp = in_exp - EXP_W'(lz);
        end else begin
            uflow_d = 1'b1;
`ifdef MULT_NORM_DENORM_EN
            // Shift only until the exponent reaches the denormal floor.
            shamt_d = SHAMT_W'(in_exp - EXP_W'(1));
`else
            s1_d.mant = '0;
            zero_d    = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
            s1_shamt <= '0;
            s1_zero  <= 1'b0;
            s1_uflow <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_q     <= s1_d;
                s1_shamt <= shamt_d;
                s1_zero  <= zero_d;
                s1_uflow <= uflow_d;
            end
        end
    end

    // Output registers only change on a load, so they hold while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid  <= 1'b0;
            out_sign  <= 1'b0;
            out_exp   <= '0;
            out_mant  <= '0;
            out_zero  <= 1'b0;
            out_uflow <= 1'b0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_sign  <= s1_q.sign;
                out_exp   <= s1_q.exp;
                out_mant  <= s1_q.mant << s1_shamt;
                out_zero  <= s1_zero;
                out_uflow <= s1_uflow;
            end
        end
    end
endmodule
